// File: rtl/mesh_router_pkg.sv
// Shared types and helpers for the mesh router: port direction encoding,
// port-count derivation and packet coordinate field positions.
package mesh_router_pkg;

    typedef enum logic [2:0] {
        DIR_P = 3'd0,
        DIR_W = 3'd1,
        DIR_E = 3'd2,
        DIR_N = 3'd3,
        DIR_S = 3'd4
    } dir_e;

    // dest_x sits at the bottom of the packet, dest_y directly above it.
    localparam int DEST_X_LSB = 0;

    function automatic int dirs_f(input int dims);
        return 2 * dims + 1;
    endfunction

    function automatic int dest_y_lsb_f(input int x_cord_width);
        return DEST_X_LSB + x_cord_width;
    endfunction

endpackage

// File: rtl/mesh_rr_arb.sv
// Round-robin arbiter: one-hot grant among n_p requesters. The priority
// pointer moves past the winner only when the granted transfer completes.
module mesh_rr_arb #(
    parameter int n_p = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [n_p-1:0] req_i,
    input  logic           ready_i,
    output logic [n_p-1:0] grant_o,
    output logic           v_o
);
    localparam int ptr_w = (n_p > 1) ? $clog2(n_p) : 1;

    logic [ptr_w-1:0] ptr_r;
    logic [ptr_w-1:0] winner;
    logic [n_p-1:0]   hi_mask;
    logic [n_p-1:0]   masked;
    logic [n_p-1:0]   pick_from;

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < n_p; k++) hi_mask[k] = (k >= int'(ptr_r));
        // Requesters at or above the pointer win first; otherwise wrap to the bottom.
        masked    = req_i & hi_mask;
        pick_from = (|masked) ? masked : req_i;
        winner    = '0;
        for (int k = n_p - 1; k >= 0; k--) begin
            if (pick_from[k]) winner = ptr_w'(k);
        end
        v_o     = |req_i;
        grant_o = '0;
        for (int k = 0; k < n_p; k++) grant_o[k] = v_o && (winner == ptr_w'(k));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            ptr_r <= '0;
        else if (v_o && ready_i)
            ptr_r <= (winner == ptr_w'(n_p - 1)) ? '0 : winner + 1'b1;
    end

endmodule

// File: rtl/mesh_router.sv
// Unbuffered single-cycle XY dimension-ordered mesh router, one round-robin
// arbiter per output. Define MESH_ROUTER_ASSERTIONS_EN for simulation routing checks.
module mesh_router
    import mesh_router_pkg::*;
#(
    parameter int  dims_p         = 2,
    parameter int  width_p        = 8,
    parameter int  x_cord_width_p = 2,
    parameter int  y_cord_width_p = 2,
    localparam int dirs           = dirs_f(dims_p)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [dirs-1:0][width_p-1:0]   data_i,
    input  logic [dirs-1:0]                v_i,
    output logic [dirs-1:0]                yumi_o,
    output logic [dirs-1:0][width_p-1:0]   data_o,
    output logic [dirs-1:0]                v_o,
    input  logic [dirs-1:0]                ready_and_i,
    input  logic [x_cord_width_p-1:0]      my_x_i,
    input  logic [y_cord_width_p-1:0]      my_y_i
);
    localparam int y_lsb = dest_y_lsb_f(x_cord_width_p);

    dir_e            route [dirs];
    logic [dirs-1:0] req   [dirs];
    logic [dirs-1:0] grant [dirs];

    // X is resolved first; only an X match lets Y (row 0 is north) decide.
    function automatic dir_e route_f(
        input logic [x_cord_width_p-1:0] dest_x,
        input logic [x_cord_width_p-1:0] my_x,
        input logic [y_cord_width_p-1:0] dest_y,
        input logic [y_cord_width_p-1:0] my_y
    );
        if (dest_x < my_x) return DIR_W;
        if (dest_x > my_x) return DIR_E;
        if (dims_p == 1)   return DIR_P;
        if (dest_y < my_y) return DIR_N;
        if (dest_y > my_y) return DIR_S;
        return DIR_P;
    endfunction

    always_comb begin
        for (int i = 0; i < dirs; i++) begin
            route[i] = route_f(data_i[i][DEST_X_LSB +: x_cord_width_p], my_x_i,
                               data_i[i][y_lsb +: y_cord_width_p], my_y_i);
        end
    end

    // Masking requests during reset clears every v_o, grant and yumi_o at once.
    always_comb begin
        for (int o = 0; o < dirs; o++) begin
            req[o] = '0;
            for (int i = 0; i < dirs; i++) req[o][i] = v_i[i] && !reset && (int'(route[i]) == o);
        end
    end

    for (genvar o = 0; o < dirs; o++) begin : g_out
        mesh_rr_arb #(.n_p(dirs)) u_arb (
            .clk     (clk),
            .reset   (reset),
            .req_i   (req[o]),
            .ready_i (ready_and_i[o]),
            .grant_o (grant[o]),
            .v_o     (v_o[o])
        );
    end

    always_comb begin
        data_o = '0;
        yumi_o = '0;
        for (int o = 0; o < dirs; o++) begin
            for (int i = 0; i < dirs; i++) begin
                if (grant[o][i]) begin
                    data_o[o] = data_i[i];
                    yumi_o[i] = yumi_o[i] | ready_and_i[o];
                end
            end
        end
    end

`ifdef MESH_ROUTER_ASSERTIONS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown(v_i)) else $error("mesh_router: X on v_i");
            for (int i = 1; i < dirs; i++) begin
                if (v_i[i]) begin
                    assert (int'(route[i]) != i)
                        else $error("mesh_router: input %0d routes back to itself", i);
                    if (i >= int'(DIR_N))
                        assert (route[i] != DIR_W && route[i] != DIR_E)
                            else $error("mesh_router: Y input %0d requests an X output", i);
                end
            end
        end
    end
`else
    // Routing checks are compiled only with MESH_ROUTER_ASSERTIONS_EN.
`endif

endmodule

// File: tb/tb_mesh_router.sv
// Self-checking bench for mesh_router: directed scenarios on a router at (1,1)
// plus a 4x4 mesh all-to-all traffic run with link FIFOs modelled in the bench.
module tb_mesh_router;
    import mesh_router_pkg::*;

    localparam int DIMS = 2;
    localparam int W = 8;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int ND = 5;
    localparam int NT = 16;
    localparam int LINK_DEPTH = 2;
    localparam int MESH_BUDGET = 3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [ND-1:0][W-1:0] data_i, data_o;
    logic [ND-1:0]        v_i, yumi_o, v_o, ready_and_i;

    mesh_router #(.dims_p(DIMS), .width_p(W), .x_cord_width_p(XW), .y_cord_width_p(YW)) dut (
        .clk(clk), .reset(reset), .data_i(data_i), .v_i(v_i), .yumi_o(yumi_o),
        .data_o(data_o), .v_o(v_o), .ready_and_i(ready_and_i),
        .my_x_i(2'd1), .my_y_i(2'd1)
    );

    logic [ND-1:0][W-1:0] m_data_i [NT];
    logic [ND-1:0][W-1:0] m_data_o [NT];
    logic [ND-1:0]        m_v_i [NT];
    logic [ND-1:0]        m_yumi [NT];
    logic [ND-1:0]        m_v_o [NT];
    logic [ND-1:0]        m_ready [NT];

    for (genvar t = 0; t < NT; t++) begin : g_tile
        mesh_router #(.dims_p(DIMS), .width_p(W), .x_cord_width_p(XW), .y_cord_width_p(YW)) u_rtr (
            .clk(clk), .reset(reset), .data_i(m_data_i[t]), .v_i(m_v_i[t]), .yumi_o(m_yumi[t]),
            .data_o(m_data_o[t]), .v_o(m_v_o[t]), .ready_and_i(m_ready[t]),
            .my_x_i(XW'(t % 4)), .my_y_i(YW'(t / 4))
        );
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q [ND][$];
    logic [W-1:0] mon_exp;
    logic [W-1:0] lq [NT][ND][$];
    int           mesh_recv [NT][NT];
    int           mesh_got;

    function automatic logic [W-1:0] mk(input logic [3:0] pay, input int x, input int y);
        return {pay, 2'(y), 2'(x)};
    endfunction

    function automatic int nb_tile(input int t, input int d);
        int x = t % 4;
        int y = t / 4;
        case (d)
            1: return (x > 0) ? t - 1 : -1;
            2: return (x < 3) ? t + 1 : -1;
            3: return (y > 0) ? t - 4 : -1;
            4: return (y < 3) ? t + 4 : -1;
            default: return -1;
        endcase
    endfunction

    function automatic int opp_dir(input int d);
        case (d)
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    // Scoreboard monitor for the directed router: every completed output transfer pops one expectation.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            for (int o = 0; o < ND; o++) begin
                if (v_o[o] && ready_and_i[o]) begin
                    n_cmp++;
                    if (exp_q[o].size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected out=%0d got=%h expected=none", o, data_o[o]);
                    end else begin
                        mon_exp = exp_q[o].pop_front();
                        if (data_o[o] !== mon_exp) begin
                            n_err++;
                            $display("FAIL sb_data out=%0d got=%h expected=%h", o, data_o[o], mon_exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < ND; d++) data_i[d] = mk(4'h0, 1, 1);
        v_i = '1;
        ready_and_i = '1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (v_o !== 5'b00000) begin n_err++; $display("FAIL reset_v_o got=%b expected=%b", v_o, 5'b00000); end
        n_cmp++;
        if (yumi_o !== 5'b00000) begin n_err++; $display("FAIL reset_yumi got=%b expected=%b", yumi_o, 5'b00000); end
        @(negedge clk);
        v_i = '0;
        reset = 1'b0;
    endtask

    task automatic test_local();
        @(negedge clk);
        v_i = 5'b00001;
        data_i[0] = 8'h55;
        ready_and_i = '1;
        exp_q[0].push_back(8'h55);
        #1;
        n_cmp++;
        if (v_o !== 5'b00001) begin n_err++; $display("FAIL local_v_o got=%b expected=%b", v_o, 5'b00001); end
        n_cmp++;
        if (yumi_o !== 5'b00001) begin n_err++; $display("FAIL local_yumi got=%b expected=%b", yumi_o, 5'b00001); end
        n_cmp++;
        if (data_o[0] !== 8'h55) begin n_err++; $display("FAIL local_data got=%h expected=%h", data_o[0], 8'h55); end
        @(negedge clk);
        v_i = '0;
    endtask

    task automatic test_routes();
        int          rx [4]   = '{3, 0, 1, 1};
        int          ry [4]   = '{1, 1, 0, 3};
        int          rd [4]   = '{2, 1, 3, 4};
        logic [ND-1:0] rv [4] = '{5'b00100, 5'b00010, 5'b01000, 5'b10000};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v_i = 5'b00001;
            data_i[0] = mk(4'(k + 1), rx[k], ry[k]);
            exp_q[rd[k]].push_back(data_i[0]);
            #1;
            n_cmp++;
            if (v_o !== rv[k]) begin n_err++; $display("FAIL route_v_o dest=(%0d,%0d) got=%b expected=%b", rx[k], ry[k], v_o, rv[k]); end
            n_cmp++;
            if (yumi_o !== 5'b00001) begin n_err++; $display("FAIL route_yumi dest=(%0d,%0d) got=%b expected=%b", rx[k], ry[k], yumi_o, 5'b00001); end
        end
        @(negedge clk);
        v_i = '0;
    endtask

    // Output P pointer is at W here (P was granted last), so W, then N, then W again.
    task automatic test_contention();
        @(negedge clk);
        v_i = 5'b01010;
        data_i[1] = mk(4'h6, 1, 1);
        data_i[3] = mk(4'h8, 1, 1);
        exp_q[0].push_back(data_i[1]);
        #1;
        n_cmp++;
        if (yumi_o !== 5'b00010) begin n_err++; $display("FAIL contend_c1 got=%b expected=%b", yumi_o, 5'b00010); end
        @(negedge clk);
        data_i[1] = mk(4'h7, 1, 1);
        exp_q[0].push_back(data_i[3]);
        #1;
        n_cmp++;
        if (yumi_o !== 5'b01000) begin n_err++; $display("FAIL contend_c2 got=%b expected=%b", yumi_o, 5'b01000); end
        @(negedge clk);
        v_i = 5'b00010;
        exp_q[0].push_back(data_i[1]);
        #1;
        n_cmp++;
        if (yumi_o !== 5'b00010) begin n_err++; $display("FAIL contend_c3 got=%b expected=%b", yumi_o, 5'b00010); end
        @(negedge clk);
        v_i = '0;
    endtask

    // W and P both want E while E stalls; the stalled grant must hold on W.
    task automatic test_backpressure();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ready_and_i = 5'b11011;
            v_i = 5'b00011;
            data_i[1] = mk(4'hA, 2, 1);
            data_i[0] = mk(4'hB, 3, 1);
            #1;
            n_cmp++;
            if (v_o !== 5'b00100) begin n_err++; $display("FAIL stall_v_o cycle=%0d got=%b expected=%b", c, v_o, 5'b00100); end
            n_cmp++;
            if (yumi_o !== 5'b00000) begin n_err++; $display("FAIL stall_yumi cycle=%0d got=%b expected=%b", c, yumi_o, 5'b00000); end
        end
        @(negedge clk);
        ready_and_i = '1;
        exp_q[2].push_back(data_i[1]);
        #1;
        n_cmp++;
        if (yumi_o !== 5'b00010) begin n_err++; $display("FAIL stall_release got=%b expected=%b", yumi_o, 5'b00010); end
        @(negedge clk);
        v_i = 5'b00001;
        exp_q[2].push_back(data_i[0]);
        #1;
        n_cmp++;
        if (yumi_o !== 5'b00001) begin n_err++; $display("FAIL stall_next got=%b expected=%b", yumi_o, 5'b00001); end
        @(negedge clk);
        v_i = '0;
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        v_i = 5'b11111;
        data_i[0] = mk(4'h1, 1, 3);
        data_i[1] = mk(4'h2, 2, 1);
        data_i[2] = mk(4'h3, 0, 1);
        data_i[3] = mk(4'h4, 1, 1);
        data_i[4] = mk(4'h5, 1, 0);
        exp_q[4].push_back(data_i[0]);
        exp_q[2].push_back(data_i[1]);
        exp_q[1].push_back(data_i[2]);
        exp_q[0].push_back(data_i[3]);
        exp_q[3].push_back(data_i[4]);
        #1;
        n_cmp++;
        if (v_o !== 5'b11111) begin n_err++; $display("FAIL simul_v_o got=%b expected=%b", v_o, 5'b11111); end
        n_cmp++;
        if (yumi_o !== 5'b11111) begin n_err++; $display("FAIL simul_yumi got=%b expected=%b", yumi_o, 5'b11111); end
        @(negedge clk);
        v_i = '0;
    endtask

    // W wins P first so the P pointer favours E; only a real reset brings P back on top.
    task automatic test_reset_midflight();
        @(negedge clk);
        v_i = 5'b00010;
        data_i[1] = mk(4'h9, 1, 1);
        exp_q[0].push_back(data_i[1]);
        #1;
        n_cmp++;
        if (yumi_o !== 5'b00010) begin n_err++; $display("FAIL midrst_pre got=%b expected=%b", yumi_o, 5'b00010); end
        @(negedge clk);
        ready_and_i = '0;
        v_i = 5'b00111;
        data_i[0] = mk(4'hC, 1, 1);
        data_i[1] = mk(4'hD, 1, 1);
        data_i[2] = mk(4'hE, 1, 1);
        #1;
        n_cmp++;
        if (v_o !== 5'b00001) begin n_err++; $display("FAIL midrst_pending_v got=%b expected=%b", v_o, 5'b00001); end
        @(negedge clk);
        reset = 1'b1;
        ready_and_i = '1;
        #1;
        n_cmp++;
        if (v_o !== 5'b00000) begin n_err++; $display("FAIL midrst_v_o got=%b expected=%b", v_o, 5'b00000); end
        n_cmp++;
        if (yumi_o !== 5'b00000) begin n_err++; $display("FAIL midrst_yumi got=%b expected=%b", yumi_o, 5'b00000); end
        @(negedge clk);
        reset = 1'b0;
        exp_q[0].push_back(data_i[0]);
        #1;
        n_cmp++;
        if (yumi_o !== 5'b00001) begin n_err++; $display("FAIL postrst_c1 got=%b expected=%b", yumi_o, 5'b00001); end
        @(negedge clk);
        v_i = 5'b00110;
        exp_q[0].push_back(data_i[1]);
        #1;
        n_cmp++;
        if (yumi_o !== 5'b00010) begin n_err++; $display("FAIL postrst_c2 got=%b expected=%b", yumi_o, 5'b00010); end
        @(negedge clk);
        v_i = 5'b00100;
        exp_q[0].push_back(data_i[2]);
        #1;
        n_cmp++;
        if (yumi_o !== 5'b00100) begin n_err++; $display("FAIL postrst_c3 got=%b expected=%b", yumi_o, 5'b00100); end
        @(negedge clk);
        v_i = '0;
    endtask

    // One mesh cycle: present FIFO heads, then move every completed transfer.
    task automatic mesh_step();
        logic [W-1:0] pkt;
        int           nt;
        @(negedge clk);
        for (int t = 0; t < NT; t++) begin
            for (int d = 0; d < ND; d++) begin
                m_v_i[t][d]    = (lq[t][d].size() != 0);
                m_data_i[t][d] = (lq[t][d].size() != 0) ? lq[t][d][0] : '0;
                nt = nb_tile(t, d);
                if (d == 0)
                    m_ready[t][d] = 1'b1;
                else
                    m_ready[t][d] = (nt >= 0) && (lq[(nt >= 0) ? nt : 0][opp_dir(d)].size() < LINK_DEPTH);
            end
        end
        #1;
        for (int t = 0; t < NT; t++) begin
            for (int d = 0; d < ND; d++) begin
                if (m_v_o[t][d] && m_ready[t][d]) begin
                    pkt = m_data_o[t][d];
                    if (d == 0) begin
                        n_cmp++;
                        if (pkt[3:0] !== {2'(t / 4), 2'(t % 4)}) begin
                            n_err++;
                            $display("FAIL mesh_eject_dest tile=%0d got=%h expected_xy=(%0d,%0d)", t, pkt, t % 4, t / 4);
                        end
                        mesh_recv[int'(pkt[7:4])][t]++;
                        mesh_got++;
                    end else begin
                        lq[nb_tile(t, d)][opp_dir(d)].push_back(pkt);
                    end
                end
            end
        end
        for (int t = 0; t < NT; t++) begin
            for (int d = 0; d < ND; d++) begin
                if (m_yumi[t][d] && lq[t][d].size() != 0) void'(lq[t][d].pop_front());
            end
        end
    endtask

    task automatic test_mesh();
        int cyc;
        for (int s = 0; s < NT; s++) begin
            for (int d = 0; d < NT; d++) begin
                mesh_recv[s][d] = 0;
                lq[s][0].push_back(mk(4'(s), d % 4, d / 4));
            end
        end
        mesh_got = 0;
        cyc = 0;
        while (mesh_got < NT * NT && cyc < MESH_BUDGET) begin
            mesh_step();
            cyc++;
        end
        n_cmp++;
        if (mesh_got !== NT * NT) begin
            n_err++;
            $display("FAIL mesh_deadlock received=%0d expected=%0d after %0d cycles", mesh_got, NT * NT, cyc);
        end
        for (int s = 0; s < NT; s++) begin
            for (int d = 0; d < NT; d++) begin
                n_cmp++;
                if (mesh_recv[s][d] !== 1) begin
                    n_err++;
                    $display("FAIL mesh_count src=%0d dst=%0d got=%0d expected=1", s, d, mesh_recv[s][d]);
                end
            end
        end
    endtask

    task automatic test_drain();
        @(negedge clk);
        #3;
        for (int o = 0; o < ND; o++) begin
            n_cmp++;
            if (exp_q[o].size() !== 0) begin
                n_err++;
                $display("FAIL sb_leftover out=%0d got=%0d pending expected=0", o, exp_q[o].size());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        v_i = '0;
        ready_and_i = '0;
        data_i = '0;
        for (int t = 0; t < NT; t++) begin
            m_v_i[t] = '0;
            m_ready[t] = '0;
            m_data_i[t] = '0;
        end
        test_reset();
        test_local();
        test_routes();
        test_contention();
        test_backpressure();
        test_simultaneous();
        test_reset_midflight();
        test_mesh();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
